// File: rtl/aux_counter_bank.sv
// Bank of NCH auxiliary counters with per-channel load/inc/dec, terminal-count compare,
// sticky overflow flags and a registered readout port. Define AUX_CNT_IRQ_EN for TC interrupts.
module aux_counter_bank #(
   parameter int WIDTH    = 6,
   parameter int NCH      = 4,
   parameter int CHW      = 2,
   parameter int SATURATE = 0
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [NCH-1:0]    clr_i,
   input  logic              en_i,
   input  logic [CHW-1:0]    ch_i,
   input  logic [1:0]        op_i,
   input  logic [WIDTH-1:0]  data_i,
   input  logic [CHW-1:0]    rd_ch_i,
   output logic [WIDTH-1:0]  cnt_o,
   output logic [NCH-1:0]    tc_o,
`ifdef AUX_CNT_IRQ_EN
   output logic              irq_o,
   input  logic [NCH-1:0]    irq_ack_i,
`endif
   output logic [NCH-1:0]    ovf_o
);

   localparam logic [1:0]       OP_LOAD  = 2'b00;
   localparam logic [1:0]       OP_INC   = 2'b01;
   localparam logic [1:0]       OP_DEC   = 2'b10;
   localparam logic [1:0]       OP_LIMIT = 2'b11;
   localparam logic [WIDTH-1:0] ALL1     = '1;
   localparam logic [WIDTH-1:0] ZERO     = '0;

   logic [WIDTH-1:0] r_cnt [NCH];
   logic [WIDTH-1:0] r_lim [NCH];
   logic [NCH-1:0]   r_ovf;
   logic [WIDTH-1:0] r_cnt_o;

   logic [WIDTH-1:0] w_cnt_nxt [NCH];
   logic [WIDTH-1:0] w_lim_nxt [NCH];
   logic [NCH-1:0]   w_ovf_nxt;
   logic [NCH-1:0]   w_tc;
   logic [WIDTH-1:0] w_rd;

   // Out-of-range channel indices never match any i, so such commands fall through.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         w_cnt_nxt[i] = r_cnt[i];
         w_lim_nxt[i] = r_lim[i];
         w_ovf_nxt[i] = r_ovf[i];
         if (clr_i[i]) begin
            w_cnt_nxt[i] = ZERO;
            w_ovf_nxt[i] = 1'b0;
         end else if (en_i && (ch_i == CHW'(i))) begin
            case (op_i)
               OP_LOAD:  w_cnt_nxt[i] = data_i;
               OP_LIMIT: w_lim_nxt[i] = data_i;
               OP_INC: begin
                  if (r_cnt[i] == ALL1) begin
                     w_ovf_nxt[i] = 1'b1;
                     w_cnt_nxt[i] = (SATURATE != 0) ? ALL1 : ZERO;
                  end else begin
                     w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                  end
               end
               OP_DEC: begin
                  if (r_cnt[i] == ZERO) begin
                     w_ovf_nxt[i] = 1'b1;
                     w_cnt_nxt[i] = (SATURATE != 0) ? ZERO : ALL1;
                  end else begin
                     w_cnt_nxt[i] = r_cnt[i] - 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      w_rd = ZERO;
      for (int i = 0; i < NCH; i++) begin
         w_tc[i] = (r_cnt[i] == r_lim[i]);
         if (rd_ch_i == CHW'(i)) w_rd = r_cnt[i];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NCH; i++) begin
            r_cnt[i] <= ZERO;
            r_lim[i] <= ALL1;
         end
         r_ovf   <= '0;
         r_cnt_o <= ZERO;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            r_cnt[i] <= w_cnt_nxt[i];
            r_lim[i] <= w_lim_nxt[i];
         end
         r_ovf   <= w_ovf_nxt;
         r_cnt_o <= w_rd;
      end
   end

   assign cnt_o = r_cnt_o;
   assign tc_o  = w_tc;
   assign ovf_o = r_ovf;

`ifdef AUX_CNT_IRQ_EN
   logic [NCH-1:0] r_tc_q;
   logic [NCH-1:0] r_pend;
   logic           r_irq;
   logic [NCH-1:0] w_pend_nxt;

   // A new rising edge beats a same-cycle acknowledge so no event is lost.
   assign w_pend_nxt = (w_tc & ~r_tc_q) | (r_pend & ~irq_ack_i);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_tc_q <= '0;
         r_pend <= '0;
         r_irq  <= 1'b0;
      end else begin
         r_tc_q <= w_tc;
         r_pend <= w_pend_nxt;
         r_irq  <= |w_pend_nxt;
      end
   end

   assign irq_o = r_irq;
`endif

endmodule

// File: tb/tb_aux_counter_bank.sv
// Directed bench for aux_counter_bank: wrap and saturate instances driven in lockstep.
module tb_aux_counter_bank;

   logic       clk = 1'b0;
   logic       rstn;
   logic [3:0] clr_i;
   logic       en_i;
   logic [1:0] ch_i;
   logic [1:0] op_i;
   logic [5:0] data_i;
   logic [1:0] rd_ch_i;
   logic [5:0] cnt_w, cnt_s;
   logic [3:0] tc_w, tc_s, ovf_w, ovf_s;
`ifdef AUX_CNT_IRQ_EN
   logic       irq_w, irq_s;
   logic [3:0] irq_ack_i;
`endif

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   aux_counter_bank #(.WIDTH(6), .NCH(4), .CHW(2), .SATURATE(0)) u_wrap (
      .clk(clk), .rstn(rstn), .clr_i(clr_i), .en_i(en_i), .ch_i(ch_i), .op_i(op_i),
      .data_i(data_i), .rd_ch_i(rd_ch_i), .cnt_o(cnt_w), .tc_o(tc_w),
`ifdef AUX_CNT_IRQ_EN
      .irq_o(irq_w), .irq_ack_i(irq_ack_i),
`endif
      .ovf_o(ovf_w));

   aux_counter_bank #(.WIDTH(6), .NCH(4), .CHW(2), .SATURATE(1)) u_sat (
      .clk(clk), .rstn(rstn), .clr_i(clr_i), .en_i(en_i), .ch_i(ch_i), .op_i(op_i),
      .data_i(data_i), .rd_ch_i(rd_ch_i), .cnt_o(cnt_s), .tc_o(tc_s),
`ifdef AUX_CNT_IRQ_EN
      .irq_o(irq_s), .irq_ack_i(irq_ack_i),
`endif
      .ovf_o(ovf_s));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic cmd(input logic [1:0] ch, input logic [1:0] op, input logic [5:0] d);
      en_i = 1'b1; ch_i = ch; op_i = op; data_i = d;
      cyc();
      en_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rstn = 1'b0; clr_i = '0; en_i = 1'b0; ch_i = '0; op_i = '0; data_i = '0; rd_ch_i = '0;
`ifdef AUX_CNT_IRQ_EN
      irq_ack_i = '0;
`endif
      cyc(); cyc();
      chk("rst_cnt", 32'(cnt_w), 0);
      chk("rst_tc", 32'(tc_w), 0);
      chk("rst_ovf", 32'(ovf_w), 0);
`ifdef AUX_CNT_IRQ_EN
      chk("rst_irq", 32'(irq_w), 0);
`endif
      rstn = 1'b1;
      cyc();
      chk("idle_cnt", 32'(cnt_w), 0);
      chk("idle_tc", 32'(tc_w), 0);

      // Reset limit is all-ones: loading 3F must hit terminal count
      cmd(2'd0, 2'b00, 6'h3F);
      chk("lim_rst_tc", 32'(tc_w), 32'b0001);
      cmd(2'd0, 2'b00, 6'h00);
      chk("ld0_tc", 32'(tc_w), 0);

      rd_ch_i = 2'd1;
      cmd(2'd1, 2'b11, 6'd5);
      cmd(2'd1, 2'b00, 6'd3);
      chk("ld_lat", 32'(cnt_w), 0);
      cmd(2'd1, 2'b01, 6'd0);
      chk("inc1_cnt", 32'(cnt_w), 3);
      cmd(2'd1, 2'b01, 6'd0);
      chk("inc2_cnt", 32'(cnt_w), 4);
      chk("inc2_tc", 32'(tc_w), 32'b0010);
      cyc();
      chk("inc_final", 32'(cnt_w), 5);

      cmd(2'd2, 2'b00, 6'h3F);
      chk("ld3f_tc", 32'(tc_w), 32'b0110);
      cmd(2'd2, 2'b01, 6'd0);
      chk("ovf_w", 32'(ovf_w), 32'b0100);
      chk("ovf_s", 32'(ovf_s), 32'b0100);
      rd_ch_i = 2'd2;
      cyc();
      chk("incwrap_cnt", 32'(cnt_w), 0);
      chk("incsat_cnt", 32'(cnt_s), 6'h3F);
      chk("incwrap_tc", 32'(tc_w), 32'b0010);
      chk("incsat_tc", 32'(tc_s), 32'b0110);

      cmd(2'd0, 2'b10, 6'd0);
      chk("dec_ovf_w", 32'(ovf_w), 32'b0101);
      chk("dec_ovf_s", 32'(ovf_s), 32'b0101);
      rd_ch_i = 2'd0;
      cyc();
      chk("decwrap_cnt", 32'(cnt_w), 6'h3F);
      chk("decsat_cnt", 32'(cnt_s), 0);
      clr_i = 4'b0001;
      cyc();
      clr_i = 4'b0001;
      cmd(2'd0, 2'b10, 6'd0);
      clr_i = '0;
      chk("clrwin_ovf_w", 32'(ovf_w), 32'b0100);
      chk("clrwin_ovf_s", 32'(ovf_s), 32'b0100);
      cyc();
      chk("clrwin_cnt", 32'(cnt_w), 0);

      cmd(2'd3, 2'b00, 6'd7);
      clr_i = 4'b1000;
      cmd(2'd1, 2'b01, 6'd0);
      clr_i = '0;
      rd_ch_i = 2'd1;
      cyc();
      chk("othclr_ch1", 32'(cnt_w), 6);
      chk("othclr_tc_w", 32'(tc_w), 0);
      chk("othclr_tc_s", 32'(tc_s), 32'b0100);
      chk("othclr_ovf", 32'(ovf_w), 32'b0100);
      rd_ch_i = 2'd3;
      cyc();
      chk("othclr_ch3", 32'(cnt_w), 0);

      cmd(2'd2, 2'b00, 6'd9);
      chk("ld_keeps_ovf", 32'(ovf_w), 32'b0100);
      chk("ld9_tc_s", 32'(tc_s), 0);

`ifdef AUX_CNT_IRQ_EN
      irq_ack_i = 4'hF;
      cyc();
      irq_ack_i = '0;
      chk("ackall_irq", 32'(irq_w), 0);
      cmd(2'd0, 2'b11, 6'd2);
      cmd(2'd0, 2'b01, 6'd0);
      cmd(2'd0, 2'b01, 6'd0);
      chk("irq_tc", 32'(tc_w), 32'b0001);
      chk("irq_pre", 32'(irq_w), 0);
      cyc();
      chk("irq_set", 32'(irq_w), 1);
      chk("irq_set_s", 32'(irq_s), 1);
      irq_ack_i = 4'b0001;
      cyc();
      irq_ack_i = '0;
      chk("irq_ack", 32'(irq_w), 0);
      cmd(2'd0, 2'b00, 6'd1);
      cmd(2'd0, 2'b00, 6'd2);
      irq_ack_i = 4'b0001;
      cyc();
      irq_ack_i = '0;
      chk("irq_setwins", 32'(irq_w), 1);
      irq_ack_i = 4'b0001;
      cyc();
      irq_ack_i = '0;
      chk("irq_ack2", 32'(irq_w), 0);
`endif

      // Asynchronous reset between edges
      #2 rstn = 1'b0;
      #1;
      chk("arst_ovf", 32'(ovf_w), 0);
      chk("arst_tc", 32'(tc_w), 0);
      chk("arst_cnt", 32'(cnt_w), 0);
      @(negedge clk);
      rstn = 1'b1;
      cyc();
      rd_ch_i = 2'd1;
      cmd(2'd1, 2'b00, 6'd4);
      cyc();
      chk("post_arst_ld", 32'(cnt_w), 4);
      chk("post_arst_tc", 32'(tc_w), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
